seq_code_checker: RTL and testbench



---
 rtl/seq_code_checker_pkg.sv | 35 +++
 rtl/seq_code_decode.sv | 34 +++
 rtl/seq_code_checker.sv | 125 ++++++++++++
 tb/tb_seq_code_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_code_checker_pkg.sv
// ============================================================================
// Module   : seq_code_checker_pkg
// Brief    : Shared code table, state encoding and index helpers for the
//            0-4-7-8-10-13-9-15 counting sequence.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_code_checker_pkg;

  localparam int IDX_W = 3;

  localparam logic [3:0] CODE_0 = 4'd0;
  localparam logic [3:0] CODE_1 = 4'd4;
  localparam logic [3:0] CODE_2 = 4'd7;
  localparam logic [3:0] CODE_3 = 4'd8;
  localparam logic [3:0] CODE_4 = 4'd10;
  localparam logic [3:0] CODE_5 = 4'd13;
  localparam logic [3:0] CODE_6 = 4'd9;
  localparam logic [3:0] CODE_7 = 4'd15;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Index 7 rolls over to 0, which is the 15 -> 0 step of the sequence.
  function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] i);
    return i + IDX_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_code_decode.sv
// ============================================================================
// Module   : seq_code_decode
// Brief    : Combinational map from a 4-bit sequence code to its index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_code_decode
  import seq_code_checker_pkg::*;
(
  input  logic [3:0]       code,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  always_comb begin
    idx   = '0;
    legal = 1'b1;
    case (code)
      CODE_0:  idx = 3'd0;
      CODE_1:  idx = 3'd1;
      CODE_2:  idx = 3'd2;
      CODE_3:  idx = 3'd3;
      CODE_4:  idx = 3'd4;
      CODE_5:  idx = 3'd5;
      CODE_6:  idx = 3'd6;
      CODE_7:  idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_code_checker.sv
// ============================================================================
// Module   : seq_code_checker
// Brief    : Lock/position monitor for the custom counting sequence; flags
//            illegal, out-of-order and wrap events with 1-cycle latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_code_checker
  import seq_code_checker_pkg::*;
#(
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [3:0]       code,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             illegal,
  output logic             mismatch,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);

  logic [IDX_W-1:0] w_dec_idx;
  logic             w_legal;
  logic             w_hit;
  logic [IDX_W-1:0] w_succ;
  logic [3:0]       w_cnt_inc;
  logic             w_err_evt;
  logic             w_err_max;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [IDX_W-1:0] r_exp;

  seq_code_decode u_decode (
    .code  (code),
    .idx   (w_dec_idx),
    .legal (w_legal)
  );

  assign w_hit     = w_legal && (w_dec_idx == r_exp);
  assign w_succ    = succ(w_dec_idx);
  assign w_cnt_inc = r_cnt + 4'd1;
  // Any sample that breaks the sequence while locked counts as an error.
  assign w_err_evt = in_valid && (r_state == LOCKED) && !w_hit;
  assign w_err_max = &err_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= HUNT;
      r_cnt     <= '0;
      r_exp     <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      mismatch  <= 1'b0;
      wrap      <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      mismatch  <= 1'b0;
      wrap      <= 1'b0;

      if (clr_err) begin
        err_cnt <= '0;
      end else if (w_err_evt && !w_err_max) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end

      if (in_valid) begin
        if (!w_legal) begin
          illegal <= 1'b1;
          locked  <= 1'b0;
          r_state <= HUNT;
          r_cnt   <= '0;
        end else begin
          idx_valid <= 1'b1;
          idx       <= w_dec_idx;
          r_exp     <= w_succ;
          case (r_state)
            ACQ: begin
              if (w_hit) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == c_lock_cnt) begin
                  r_state <= LOCKED;
                  locked  <= 1'b1;
                end
              end else begin
                r_cnt <= '0;
              end
            end
            LOCKED: begin
              if (w_hit) begin
                // Expected index 0 can only follow index 7, i.e. code 15.
                wrap <= (w_dec_idx == '0);
              end else begin
                mismatch <= 1'b1;
                locked   <= 1'b0;
                r_state  <= ACQ;
                r_cnt    <= '0;
              end
            end
            default: begin
              r_state <= ACQ;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_code_checker.sv
// ============================================================================
// Module   : tb_seq_code_checker
// Brief    : Directed-vector bench with a streak-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_code_checker;

  localparam int LOCK = 2;
  localparam logic [3:0] TBL [8] = '{4'd0, 4'd4, 4'd7, 4'd8, 4'd10, 4'd13, 4'd9, 4'd15};

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       in_valid = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] code = 4'd0;

  logic [2:0] idx, idx8;
  logic       iv, ill, mm, wr, lk;
  logic       iv8, ill8, mm8, wr8, lk8;
  logic [1:0] err2;
  logic [7:0] err8;

  int total = 0;
  int bad   = 0;

  seq_code_checker #(.LOCK_CNT(LOCK), .ERR_W(2)) u_dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .code(code), .clr_err(clr_err),
    .idx(idx), .idx_valid(iv), .illegal(ill), .mismatch(mm), .wrap(wr),
    .locked(lk), .err_cnt(err2)
  );

  seq_code_checker #(.LOCK_CNT(LOCK), .ERR_W(8)) u_dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .code(code), .clr_err(clr_err),
    .idx(idx8), .idx_valid(iv8), .illegal(ill8), .mismatch(mm8), .wrap(wr8),
    .locked(lk8), .err_cnt(err8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (TBL[i] == c) return i;
    return -1;
  endfunction

  // Reference model: locked means at least LOCK correct successors since the
  // last anchor; the expected code is always the successor of the last legal one.
  bit m_hunt = 1'b1;
  int m_last = 0, m_streak = 0, m_idx = 0, m_err2 = 0, m_err8 = 0;
  bit m_iv = 0, m_ill = 0, m_mm = 0, m_wr = 0, m_lk = 0;

  task automatic m_reset();
    m_hunt = 1'b1; m_last = 0; m_streak = 0; m_idx = 0; m_err2 = 0; m_err8 = 0;
    m_iv = 0; m_ill = 0; m_mm = 0; m_wr = 0; m_lk = 0;
  endtask

  task automatic m_step();
    int ix;
    bit inc;
    inc = 1'b0;
    m_iv = 0; m_ill = 0; m_mm = 0; m_wr = 0;
    if (in_valid) begin
      ix = lookup(code);
      if (ix < 0) begin
        m_ill = 1; inc = m_lk; m_hunt = 1; m_streak = 0; m_lk = 0;
      end else begin
        m_iv = 1;
        if (m_hunt) begin
          m_hunt = 0; m_streak = 0;
        end else if (ix == (m_last + 1) % 8) begin
          if (m_streak < 100) m_streak++;
          m_wr = m_lk && (ix == 0);
        end else begin
          m_mm = m_lk; inc = m_lk; m_streak = 0;
        end
        m_last = ix; m_idx = ix;
        m_lk = (m_streak >= LOCK);
      end
    end
    if (clr_err) begin
      m_err2 = 0; m_err8 = 0;
    end else if (inc) begin
      if (m_err2 < 3) m_err2++;
      if (m_err8 < 255) m_err8++;
    end
  endtask

  always @(posedge clr) m_reset();

  always @(posedge clk) begin
    if (clr) m_reset();
    else m_step();
    #1;
    chk("idx", idx, m_idx);
    chk("idx_valid", iv, m_iv);
    chk("illegal", ill, m_ill);
    chk("mismatch", mm, m_mm);
    chk("wrap", wr, m_wr);
    chk("locked", lk, m_lk);
    chk("err_cnt2", err2, m_err2);
    chk("err_cnt8", err8, m_err8);
    chk("locked8", lk8, m_lk);
    chk("idx8", {iv8, ill8, mm8, wr8, idx8}, {m_iv, m_ill, m_mm, m_wr, 3'(m_idx)});
  end

  task automatic send(input logic [3:0] c, input logic ce);
    @(negedge clk);
    in_valid = 1'b1; code = c; clr_err = ce;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0; clr_err = 1'b0;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    @(posedge clk); #2;
    chk("rst_idx", idx, 0); chk("rst_locked", lk, 0); chk("rst_err", err2, 0);
    @(negedge clk); clr = 1'b0;

    // Acquisition
    send(4'd0, 0);  chk("acq0_idx", idx, 0); chk("acq0_iv", iv, 1); chk("acq0_lk", lk, 0);
    send(4'd4, 0);  chk("acq4_idx", idx, 1); chk("acq4_lk", lk, 0);
    send(4'd7, 0);  chk("acq7_idx", idx, 2); chk("acq7_lk", lk, 1);
    send(4'd8, 0);  chk("acq8_idx", idx, 3); chk("acq8_err", err8, 0);

    // Full cycle with wrap
    send(4'd10, 0); send(4'd13, 0); send(4'd9, 0);
    send(4'd15, 0); chk("w15_idx", idx, 7); chk("w15_wrap", wr, 0);
    send(4'd0, 0);  chk("w0_idx", idx, 0); chk("w0_wrap", wr, 1); chk("w0_lk", lk, 1);
    send(4'd4, 0);  chk("w4_wrap", wr, 0); chk("w4_mm", mm, 0);

    // Out-of-order
    send(4'd7, 0); send(4'd8, 0);
    send(4'd13, 0); chk("oo_mm", mm, 1); chk("oo_err", err2, 1); chk("oo_lk", lk, 0);
    send(4'd9, 0);  chk("oo9_lk", lk, 0);
    send(4'd15, 0); chk("oo15_lk", lk, 1); chk("oo15_idx", idx, 7);

    // Illegal and gaps
    send(4'd3, 0);  chk("il_ill", ill, 1); chk("il_iv", iv, 0); chk("il_idx", idx, 7);
    chk("il_err", err2, 2); chk("il_lk", lk, 0);
    idle(5);        chk("gap_idx", idx, 7); chk("gap_err", err8, 2); chk("gap_ill", ill, 0);
    send(4'd3, 0);  chk("hunt_ill", ill, 1); chk("hunt_err", err8, 2);

    // Saturation and clr_err
    @(negedge clk); in_valid = 1'b0; clr_err = 1'b1;
    @(posedge clk); #2; chk("clr_err2", err2, 0); chk("clr_err8", err8, 0);
    a = 0;
    for (int n = 0; n < 5; n++) begin
      send(TBL[a], 0); send(TBL[(a + 1) % 8], 0); send(TBL[(a + 2) % 8], 0);
      send(TBL[(a + 4) % 8], 0);
      a = (a + 4) % 8;
    end
    chk("sat_err2", err2, 3); chk("sat_err8", err8, 5);
    send(TBL[a], 0); send(TBL[(a + 1) % 8], 0); send(TBL[(a + 2) % 8], 0);
    chk("pre6_lk", lk, 1);
    send(TBL[(a + 4) % 8], 1); chk("six_mm", mm, 1); chk("six_err2", err2, 0);
    chk("six_err8", err8, 0);

    // Asynchronous reset mid-run
    send(4'd4, 0); send(4'd7, 0); send(4'd13, 0); send(4'd9, 0); send(4'd15, 0);
    idle(1);        chk("ar_pre_lk", lk, 1); chk("ar_pre_err", err2, 1);
    #1 clr = 1'b1;
    #1;
    chk("ar_lk", lk, 0); chk("ar_err", err2, 0); chk("ar_idx", idx, 0);
    chk("ar_pulses", {iv, ill, mm, wr}, 0);
    @(negedge clk); clr = 1'b0;
    send(4'd8, 0);  chk("post_idx", idx, 3); chk("post_iv", iv, 1); chk("post_lk", lk, 0);
    send(4'd10, 0); chk("post10_lk", lk, 0);
    send(4'd13, 0); chk("post13_lk", lk, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
